anita3_trigger_event_buffer: RTL and testbench

Sits directly downstream of the simple phi-sector trigger. It captures the per-phi trigger pattern, a 250 MHz timestamp and the trigger-count word for every issued trigger, and queues them as event records in a small FIFO. The TURF readout drains the queue over a valid/ready handshake. Triggers that cannot be queued are dropped and counted, never silently lost.

---
 rtl/anita3_trigger_pkg.sv | 27 ++
 rtl/anita3_event_fifo.sv | 72 +++++++
 rtl/anita3_trigger_event_buffer.sv | 158 +++++++++++++++
 tb/tb_anita3_trigger_event_buffer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/anita3_trigger_pkg.sv
// Shared definitions for the ANITA-3 trigger event buffer: record layout,
// default sizes and capture FSM encodings.
package anita3_trigger_pkg;

    localparam int NUM_PHI_DEF = 16;
    localparam int TS_BITS_DEF = 16;
    localparam int COUNT_W     = 8;
    localparam int SEQ_W       = 8;

    // Record is {phi, time, count, seq}, with seq in the least significant bits.
    localparam int SEQ_LSB     = 0;
    localparam int COUNT_LSB   = SEQ_LSB + SEQ_W;
    localparam int TS_LSB      = COUNT_LSB + COUNT_W;
    localparam int PHI_LSB_DEF = TS_LSB + TS_BITS_DEF;
    localparam int REC_W_DEF   = PHI_LSB_DEF + 2 * NUM_PHI_DEF;

    function automatic int rec_width(input int num_phi, input int ts_bits);
        return TS_LSB + ts_bits + 2 * num_phi;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PEND   = 2'd1,
        ST_COMMIT = 2'd2
    } cap_state_e;

endpackage

// File: rtl/anita3_event_fifo.sv
// First-word-fall-through register FIFO; the head is presented whenever the
// FIFO is non-empty and reads as zero when empty.
module anita3_event_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   fill_o
);

    localparam int AW     = $clog2(DEPTH);
    localparam int FILL_W = AW + 1;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              push_ok;
    logic              pop_ok;

    assign full_o  = (fill_q == FILL_W'(DEPTH));
    assign empty_o = (fill_q == '0);
    assign fill_o  = fill_q;
    assign push_ok = push_i && !full_o && !clear_i;
    assign pop_ok  = pop_i && !empty_o && !clear_i;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   fill_d = fill_q + FILL_W'(1);
                2'b01:   fill_d = fill_q - FILL_W'(1);
                default: fill_d = fill_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // Storage carries no reset: it is only observable through the empty gate.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/anita3_trigger_event_buffer.sv
// Captures phi pattern, timestamp and delayed count word per trigger edge and
// queues them as sequenced event records; unqueueable triggers are counted.
module anita3_trigger_event_buffer
    import anita3_trigger_pkg::*;
#(
    parameter int NUM_PHI     = NUM_PHI_DEF,
    parameter int DEPTH       = 4,
    parameter int TS_BITS     = TS_BITS_DEF,
    parameter int COUNT_DELAY = 3
) (
    input  logic                      clk250_i,
    input  logic                      rst_i,
    input  logic                      trig_i,
    input  logic [2*NUM_PHI-1:0]      phi_i,
    input  logic [COUNT_W-1:0]        count_i,
    input  logic                      pps_i,
    input  logic                      clear_i,
    output logic                      ev_valid_o,
    input  logic                      ev_ready_i,
    output logic [2*NUM_PHI-1:0]      ev_phi_o,
    output logic [TS_BITS-1:0]        ev_time_o,
    output logic [COUNT_W-1:0]        ev_count_o,
    output logic [SEQ_W-1:0]          ev_seq_o,
    output logic [$clog2(DEPTH):0]    fill_o,
    output logic                      overflow_o,
    output logic [7:0]                drop_count_o
);

    localparam int PHI_W   = 2 * NUM_PHI;
    localparam int PHI_LSB = TS_LSB + TS_BITS;
    localparam int REC_W   = rec_width(NUM_PHI, TS_BITS);

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] n);
        logic [8:0] s;
        s = {1'b0, a} + {7'b0, n};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    cap_state_e        state_q, state_d;
    logic [3:0]        dly_q, dly_d;
    logic              trig_q;
    logic [TS_BITS-1:0] ts_q, ts_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic [7:0]        drop_q, drop_d;
    logic              ovf_q, ovf_d;
    logic [PHI_W-1:0]  cap_phi_q, cap_phi_d;
    logic [TS_BITS-1:0] cap_ts_q, cap_ts_d;
    logic [COUNT_W-1:0] cap_cnt_q, cap_cnt_d;

    logic              trig_edge;
    logic              push;
    logic [1:0]        drops;
    logic              fifo_full;
    logic              fifo_empty;
    logic [REC_W-1:0]  fifo_rec;

    assign trig_edge = trig_i && !trig_q;
    assign ts_d      = pps_i ? '0 : ts_q + TS_BITS'(1);

    always_comb begin
        state_d   = state_q;
        dly_d     = dly_q;
        seq_d     = seq_q;
        cap_phi_d = cap_phi_q;
        cap_ts_d  = cap_ts_q;
        cap_cnt_d = cap_cnt_q;
        push      = 1'b0;
        drops     = 2'd0;
        case (state_q)
            ST_IDLE: begin
                if (trig_edge) begin
                    cap_phi_d = phi_i;
                    cap_ts_d  = ts_q;
                    dly_d     = 4'(COUNT_DELAY - 1);
                    state_d   = ST_PEND;
                end
            end
            ST_PEND: begin
                if (trig_edge) drops = drops + 2'd1;
                if (dly_q == 4'd0) begin
                    cap_cnt_d = count_i;
                    state_d   = ST_COMMIT;
                end else begin
                    dly_d = dly_q - 4'd1;
                end
            end
            ST_COMMIT: begin
                if (trig_edge) drops = drops + 2'd1;
                // Fullness is judged before any same-cycle pop.
                if (fifo_full) drops = drops + 2'd1;
                else           push  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (push) seq_d = seq_q + SEQ_W'(1);
        drop_d = sat_add8(drop_q, drops);
        ovf_d  = ovf_q || (drops != 2'd0);
        if (clear_i) begin
            state_d = ST_IDLE;
            push    = 1'b0;
            seq_d   = '0;
            drop_d  = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk250_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            dly_q   <= '0;
            trig_q  <= 1'b0;
            ts_q    <= '0;
            seq_q   <= '0;
            drop_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            trig_q  <= trig_i;
            ts_q    <= ts_d;
            seq_q   <= seq_d;
            drop_q  <= drop_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk250_i) begin
        cap_phi_q <= cap_phi_d;
        cap_ts_q  <= cap_ts_d;
        cap_cnt_q <= cap_cnt_d;
    end

    anita3_event_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk250_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .push_i  (push),
        .pop_i   (ev_valid_o && ev_ready_i),
        .data_i  ({cap_phi_q, cap_ts_q, cap_cnt_q, seq_q}),
        .data_o  (fifo_rec),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .fill_o  (fill_o)
    );

    assign ev_valid_o   = !fifo_empty;
    assign ev_phi_o     = fifo_rec[PHI_LSB +: PHI_W];
    assign ev_time_o    = fifo_rec[TS_LSB +: TS_BITS];
    assign ev_count_o   = fifo_rec[COUNT_LSB +: COUNT_W];
    assign ev_seq_o     = fifo_rec[SEQ_LSB +: SEQ_W];
    assign overflow_o   = ovf_q;
    assign drop_count_o = drop_q;

endmodule

// File: tb/tb_anita3_trigger_event_buffer.sv
// Directed bench for anita3_trigger_event_buffer: timeline-level reference
// model compared every cycle, plus literal expectations at key points.
module tb_anita3_trigger_event_buffer;

    localparam int NUM_PHI = 16;
    localparam int DEPTH   = 4;
    localparam int TS_BITS = 16;
    localparam int CD      = 3;

    logic        clk250_i = 1'b0;
    logic        rst_i    = 1'b1;
    logic        trig_i   = 1'b0;
    logic [31:0] phi_i    = '0;
    logic [7:0]  count_i  = '0;
    logic        pps_i    = 1'b0;
    logic        clear_i  = 1'b0;
    logic        ev_ready_i = 1'b0;
    logic        ev_valid_o;
    logic [31:0] ev_phi_o;
    logic [15:0] ev_time_o;
    logic [7:0]  ev_count_o;
    logic [7:0]  ev_seq_o;
    logic [2:0]  fill_o;
    logic        overflow_o;
    logic [7:0]  drop_count_o;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    anita3_trigger_event_buffer #(
        .NUM_PHI(NUM_PHI), .DEPTH(DEPTH), .TS_BITS(TS_BITS), .COUNT_DELAY(CD)
    ) dut (
        .clk250_i(clk250_i), .rst_i(rst_i), .trig_i(trig_i), .phi_i(phi_i),
        .count_i(count_i), .pps_i(pps_i), .clear_i(clear_i),
        .ev_valid_o(ev_valid_o), .ev_ready_i(ev_ready_i), .ev_phi_o(ev_phi_o),
        .ev_time_o(ev_time_o), .ev_count_o(ev_count_o), .ev_seq_o(ev_seq_o),
        .fill_o(fill_o), .overflow_o(overflow_o), .drop_count_o(drop_count_o)
    );

    always #5 clk250_i = ~clk250_i;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an event occupies the capture path from its edge at
    // cycle t until its commit at t+CD+1; any edge while busy is a drop.
    typedef struct {
        logic [31:0] phi;
        logic [15:0] ts;
        logic [7:0]  cnt;
        logic [7:0]  seq;
    } rec_t;

    rec_t        q[$];
    rec_t        p_rec;
    rec_t        tmp;
    logic [7:0]  m_seq  = 0;
    int          m_drop = 0;
    bit          m_ovf  = 0;
    logic [15:0] m_ts   = 0;
    bit          m_prev = 0;
    bit          pend   = 0;
    longint      cyc_n  = 0;
    longint      p_samp, p_commit;

    task automatic m_drop1();
        m_drop = (m_drop >= 255) ? 255 : m_drop + 1;
        m_ovf  = 1;
    endtask

    always @(posedge clk250_i or posedge rst_i) begin
        if (rst_i) begin
            q.delete();
            m_seq = 0; m_drop = 0; m_ovf = 0; m_ts = 0; m_prev = 0; pend = 0; cyc_n = 0;
        end else begin
            bit edge_s, full_pre, busy;
            edge_s   = trig_i && !m_prev;
            m_prev   = trig_i;
            full_pre = (q.size() == DEPTH);
            if (ev_ready_i && q.size() > 0) tmp = q.pop_front();
            if (clear_i) begin
                q.delete();
                m_seq = 0; m_drop = 0; m_ovf = 0; pend = 0;
            end else begin
                busy = pend;
                if (pend && cyc_n == p_samp) p_rec.cnt = count_i;
                if (pend && cyc_n == p_commit) begin
                    if (full_pre) m_drop1();
                    else begin
                        p_rec.seq = m_seq;
                        q.push_back(p_rec);
                        m_seq = m_seq + 8'd1;
                    end
                    pend = 0;
                end
                if (edge_s) begin
                    if (busy) m_drop1();
                    else begin
                        pend      = 1;
                        p_rec.phi = phi_i;
                        p_rec.ts  = m_ts;
                        p_samp    = cyc_n + CD;
                        p_commit  = cyc_n + CD + 1;
                    end
                end
            end
            m_ts  = pps_i ? 16'd0 : m_ts + 16'd1;
            cyc_n = cyc_n + 1;
        end
    end

    always @(negedge clk250_i) begin
        if (chk_en) begin
            chk("valid", ev_valid_o, q.size() != 0);
            chk("fill", fill_o, q.size());
            chk("overflow", overflow_o, m_ovf);
            chk("drop_count", drop_count_o, m_drop);
            if (q.size() > 0) begin
                chk("ev_phi", ev_phi_o, q[0].phi);
                chk("ev_time", ev_time_o, q[0].ts);
                chk("ev_count", ev_count_o, q[0].cnt);
                chk("ev_seq", ev_seq_o, q[0].seq);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk250_i);
        #1;
    endtask

    task automatic pulse(input logic [31:0] phi, input logic [7:0] cnt, input int hi, input int lo);
        phi_i = phi; count_i = cnt; trig_i = 1'b1;
        cyc(hi);
        trig_i = 1'b0;
        cyc(lo);
    endtask

    task automatic drain_and_clear();
        ev_ready_i = 1'b1;
        cyc(DEPTH + 1);
        ev_ready_i = 1'b0;
        clear_i = 1'b1;
        cyc(1);
        clear_i = 1'b0;
    endtask

    initial begin
        cyc(2);
        chk_en = 1;
        chk("rst_valid", ev_valid_o, 0);
        chk("rst_fill", fill_o, 0);
        chk("rst_drop", drop_count_o, 0);
        chk("rst_ovf", overflow_o, 0);
        chk("rst_phi", ev_phi_o, 0);
        rst_i = 1'b0;
        cyc(1);

        // Basic capture with timestamp 0x123 at the edge
        pps_i = 1'b1;
        cyc(1);
        pps_i = 1'b0;
        cyc(32'h123);
        phi_i = 32'h0003_0180; count_i = 8'hAA; trig_i = 1'b1;
        cyc(1);
        cyc(2);
        count_i = 8'h05;
        cyc(1);
        count_i = 8'hEE; trig_i = 1'b0;
        chk("basic_not_yet", ev_valid_o, 0);
        cyc(1);
        chk("basic_valid", ev_valid_o, 1);
        chk("basic_phi", ev_phi_o, 32'h0003_0180);
        chk("basic_time", ev_time_o, 16'h0123);
        chk("basic_count", ev_count_o, 8'h05);
        chk("basic_seq", ev_seq_o, 0);
        chk("basic_fill", fill_o, 1);
        drain_and_clear();

        // Overflow: five triggers, no pops
        for (int i = 0; i < 5; i++) pulse(32'h1000_0001 << i, 8'h10 + 8'(i), 2, 38);
        chk("ovf_fill", fill_o, 4);
        chk("ovf_drop", drop_count_o, 1);
        chk("ovf_flag", overflow_o, 1);
        for (int i = 0; i < 4; i++) begin
            chk("ovf_seq_order", ev_seq_o, i);
            ev_ready_i = 1'b1;
            cyc(1);
            ev_ready_i = 1'b0;
        end
        chk("ovf_drained", fill_o, 0);
        drain_and_clear();

        // Retrigger during PEND
        pulse(32'hDEAD_BEEF, 8'h21, 1, 1);
        pulse(32'h1234_5678, 8'h22, 1, 10);
        chk("retrig_fill", fill_o, 1);
        chk("retrig_drop", drop_count_o, 1);
        drain_and_clear();

        // Backpressure with a push coinciding with a pop
        pulse(32'h0000_00A1, 8'h31, 1, 10);
        pulse(32'h0000_00A2, 8'h32, 1, 10);
        phi_i = 32'h0000_00A3; count_i = 8'h33;
        for (int k = 0; k < 12; k++) begin
            trig_i     = (k < 2);
            ev_ready_i = (k >= 1) && (k % 2 == 0);
            cyc(1);
            if (k == 3) chk("bp_fill_before", fill_o, 1);
            if (k == 4) chk("bp_fill_coincident", fill_o, 1);
        end
        ev_ready_i = 1'b0;
        chk("bp_empty", fill_o, 0);
        drain_and_clear();

        // PPS then trigger ten cycles later
        pps_i = 1'b1;
        cyc(1);
        pps_i = 1'b0;
        cyc(9);
        pulse(32'h8000_0000, 8'h44, 1, 6);
        chk("pps_time", ev_time_o, 9);

        // Forced drops to saturation
        for (int i = 0; i < 300; i++) pulse(32'h5555_AAAA, 8'h55, 1, 1);
        cyc(10);
        chk("sat_drop", drop_count_o, 255);
        chk("sat_ovf", overflow_o, 1);
        drain_and_clear();

        // clear_i during PEND with three queued entries
        for (int i = 0; i < 3; i++) pulse(32'h0F00_0000 + 32'(i), 8'h60 + 8'(i), 1, 9);
        chk("clr_pre_fill", fill_o, 3);
        trig_i = 1'b1; phi_i = 32'h0BAD_0BAD;
        cyc(1);
        trig_i = 1'b0;
        cyc(1);
        clear_i = 1'b1;
        cyc(1);
        clear_i = 1'b0;
        chk("clr_fill", fill_o, 0);
        cyc(10);
        chk("clr_no_commit", fill_o, 0);
        pulse(32'h0000_7777, 8'h77, 1, 8);
        chk("clr_next_fill", fill_o, 1);
        chk("clr_next_seq", ev_seq_o, 0);

        // Asynchronous reset mid-PEND after a drop
        pulse(32'h0000_1111, 8'h11, 1, 1);
        trig_i = 1'b1;
        cyc(1);
        chk("pre_rst_drop", drop_count_o, 1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("arst_valid", ev_valid_o, 0);
        chk("arst_fill", fill_o, 0);
        chk("arst_drop", drop_count_o, 0);
        chk("arst_ovf", overflow_o, 0);
        chk("arst_phi", ev_phi_o, 0);
        chk("arst_time", ev_time_o, 0);
        chk("arst_seq", ev_seq_o, 0);
        trig_i = 1'b0;
        cyc(2);
        rst_i = 1'b0;
        cyc(3);
        pulse(32'h0000_2222, 8'h22, 1, 8);
        chk("post_rst_seq", ev_seq_o, 0);
        chk("post_rst_fill", fill_o, 1);
        cyc(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
